// File: rtl/bwd_token_elastic_pipe.sv
// Elastic backward-token ingress: DEPTH collapsing stages + 1 skid entry, latency DEPTH, registered in_ready (no out_ready->in_ready path).
// Optional `BWD_BUBBLE_SQUASH_EN: BUBBLE tokens are consumed but not stored, counted on drop_cnt.
module bwd_token_elastic_pipe #(
    parameter int DATA_W   = 512,
    parameter int STATUS_W = 6,
    parameter int RNUM_W   = 9,
    parameter int DEPTH    = 2,
    parameter logic [STATUS_W-1:0] BUBBLE = 6'b110000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [STATUS_W-1:0] in_status,
    input  logic [RNUM_W-1:0]   in_read_num,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [STATUS_W-1:0] out_status,
    output logic [RNUM_W-1:0]   out_read_num,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          occupancy
`ifdef BWD_BUBBLE_SQUASH_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int CAP = DEPTH + 1;

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [RNUM_W-1:0]   read_num;
        logic [DATA_W-1:0]   data;
    } tok_t;

    tok_t             stage [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    tok_t             skid;
    logic             skid_vld;

    tok_t             in_tok;
    logic [DEPTH-1:0] mv;
    logic             acc0;
    logic             push, pop, store;
    logic             skid_mv, in_to_s0, in_to_skid;
    logic [2:0]       occ_next;

    assign in_tok = '{status: in_status, read_num: in_read_num, data: in_data};

    // A stage advances when some stage downstream of it is empty or the head pops.
    always_comb begin
        logic room;
        room = out_ready;
        mv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mv[i] = stage_vld[i] & room;
            room  = room | ~stage_vld[i];
        end
        acc0 = room;
    end

    assign push = in_valid & in_ready;
    assign pop  = stage_vld[DEPTH-1] & out_ready;
`ifdef BWD_BUBBLE_SQUASH_EN
    assign store = push & (in_status != BUBBLE);
`else
    assign store = push;
`endif

    // The skid only fills when stage 0 is blocked, and always drains first to keep order.
    assign skid_mv    = skid_vld & acc0;
    assign in_to_s0   = store & ~skid_vld & acc0;
    assign in_to_skid = store & (skid_vld | ~acc0);
    assign occ_next   = occupancy + {2'b00, store} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            skid_vld  <= 1'b0;
            skid      <= '0;
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            occupancy <= 3'd0;
            in_ready  <= 1'b1;
`ifdef BWD_BUBBLE_SQUASH_EN
            drop_cnt  <= 16'd0;
`endif
        end else if (flush) begin
            stage_vld <= '0;
            skid_vld  <= 1'b0;
            occupancy <= 3'd0;
            in_ready  <= 1'b1;
`ifdef BWD_BUBBLE_SQUASH_EN
            drop_cnt  <= 16'd0;
`endif
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (mv[i-1]) stage[i] <= stage[i-1];
                stage_vld[i] <= (stage_vld[i] & ~mv[i]) | mv[i-1];
            end
            if (skid_mv)       stage[0] <= skid;
            else if (in_to_s0) stage[0] <= in_tok;
            stage_vld[0] <= (stage_vld[0] & ~mv[0]) | skid_mv | in_to_s0;

            if (in_to_skid) begin
                skid     <= in_tok;
                skid_vld <= 1'b1;
            end else if (skid_mv) begin
                skid_vld <= 1'b0;
            end

            occupancy <= occ_next;
            in_ready  <= (occ_next < 3'(CAP));
`ifdef BWD_BUBBLE_SQUASH_EN
            if (push && (in_status == BUBBLE) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
`endif
        end
    end

    assign out_valid    = stage_vld[DEPTH-1];
    assign out_status   = out_valid ? stage[DEPTH-1].status : BUBBLE;
    assign out_read_num = stage[DEPTH-1].read_num;
    assign out_data     = stage[DEPTH-1].data;

endmodule

// File: tb/tb_bwd_token_elastic_pipe.sv
// Randomized bench for bwd_token_elastic_pipe against a queue model of token order and timing.
module tb_bwd_token_elastic_pipe;

    localparam int DATA_W   = 512;
    localparam int STATUS_W = 6;
    localparam int RNUM_W   = 9;
    localparam int DEPTH    = 2;
    localparam int CAP      = DEPTH + 1;
    localparam logic [STATUS_W-1:0] BUBBLE = 6'b110000;
    localparam int NCYC     = 3000;

    logic                clk = 1'b0;
    logic                rst, flush, in_valid, out_ready;
    logic                in_ready, out_valid;
    logic [STATUS_W-1:0] in_status, out_status;
    logic [RNUM_W-1:0]   in_read_num, out_read_num;
    logic [DATA_W-1:0]   in_data, out_data;
    logic [2:0]          occupancy;
`ifdef BWD_BUBBLE_SQUASH_EN
    logic [15:0]         drop_cnt;
`endif

    always #5 clk = ~clk;

    bwd_token_elastic_pipe #(
        .DATA_W(DATA_W), .STATUS_W(STATUS_W), .RNUM_W(RNUM_W),
        .DEPTH(DEPTH), .BUBBLE(BUBBLE)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_status(in_status), .in_read_num(in_read_num), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_status(out_status), .out_read_num(out_read_num), .out_data(out_data),
        .occupancy(occupancy)
`ifdef BWD_BUBBLE_SQUASH_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    // Model: FIFO of tokens with their push cycle. The head is visible DEPTH
    // cycles after its push, but never before the cycle after its predecessor popped.
    typedef struct {
        logic [STATUS_W-1:0] st;
        logic [RNUM_W-1:0]   rn;
        logic [DATA_W-1:0]   dat;
        int                  pc;
    } mtok_t;

    mtok_t q[$];
    int    last_pop;
    bit    m_rdy;
    int    m_drop;
    int    cyc;
    int    n_chk = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit head_vld();
        int t;
        if (q.size() == 0) return 1'b0;
        t = q[0].pc + DEPTH;
        if (last_pop + 1 > t) t = last_pop + 1;
        return cyc >= t;
    endfunction

    task automatic model_clear();
        q.delete();
        m_rdy    = 1'b1;
        last_pop = -100;
        m_drop   = 0;
    endtask

    task automatic check_outputs();
        bit hv;
        hv = head_vld();
        chk("out_valid", DATA_W'(out_valid), DATA_W'(hv));
        chk("out_status", DATA_W'(out_status), DATA_W'(hv ? q[0].st : BUBBLE));
        if (hv) begin
            chk("out_read_num", DATA_W'(out_read_num), DATA_W'(q[0].rn));
            chk("out_data", out_data, q[0].dat);
        end
        chk("occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
        chk("in_ready", DATA_W'(in_ready), DATA_W'(m_rdy));
`ifdef BWD_BUBBLE_SQUASH_EN
        chk("drop_cnt", DATA_W'(drop_cnt), DATA_W'(m_drop));
`endif
    endtask

    task automatic model_step();
        bit    do_pop, do_push, squash;
        mtok_t t;
        if (rst || flush) begin
            model_clear();
            return;
        end
        do_pop  = head_vld() && out_ready;
        do_push = in_valid && m_rdy;
        if (do_pop) begin
            void'(q.pop_front());
            last_pop = cyc;
        end
        squash = 1'b0;
`ifdef BWD_BUBBLE_SQUASH_EN
        squash = (in_status == BUBBLE);
`endif
        if (do_push) begin
            if (squash) begin
                if (m_drop < 16'hFFFF) m_drop++;
            end else begin
                t.st  = in_status;
                t.rn  = in_read_num;
                t.dat = in_data;
                t.pc  = cyc;
                q.push_back(t);
            end
        end
        m_rdy = (q.size() < CAP);
    endtask

    initial begin
        int p_in, p_out, ph;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_status = '0; in_read_num = '0; in_data = '0;
        cyc = 0;
        @(posedge clk); #1;
        model_clear();
        chk("rst_out_data", out_data, '0);
        chk("rst_out_read_num", DATA_W'(out_read_num), '0);

        for (cyc = 1; cyc < NCYC; cyc++) begin
            check_outputs();

            ph = (cyc / 200) % 5;
            case (ph)
                0: begin p_in = 90;  p_out = 90; end
                1: begin p_in = 90;  p_out = 20; end
                2: begin p_in = 30;  p_out = 90; end
                3: begin p_in = 100; p_out = 50; end
                default: begin p_in = 60; p_out = 60; end
            endcase
            rst       = ($urandom_range(299, 0) == 0);
            flush     = ($urandom_range(99, 0) == 0);
            in_valid  = ($urandom_range(99, 0) < p_in);
            out_ready = ($urandom_range(99, 0) < p_out);
            in_status = ($urandom_range(3, 0) == 0) ? BUBBLE : STATUS_W'($urandom_range(63, 0));
            in_read_num = RNUM_W'($urandom);
            for (int k = 0; k < DATA_W / 32; k++) in_data[k*32 +: 32] = $urandom;

            model_step();
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
